uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the UART transmitter. It recovers 8N1 frames (start 0, 8 data bits LSB first, stop 1) from an asynchronous `rxd` line using an oversampling tick. Each good byte is delivered through a one-entry valid/ready holding register; framing errors and overruns are flagged. It shares the baud-tick generator with the transmitter, running at OSR times the transmit bit rate.

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver driven by an OSR-times-baud tick enable.
// Ports: clk, rst (sync, active high), clk_uart_os (tick), rxd (async line),
//        data/valid/ready (one-entry holding register), frame_err, overrun, busy.
module uart_rx #(
    parameter int OSR = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_uart_os,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] HALF = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(OSR - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   os_cnt;
    logic [CW-1:0]   os_nx;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_nx;
    logic [7:0]      shift;
    logic [7:0]      shift_nx;
    logic            sync1;
    logic            rxd_s;
    logic            offer;
    logic            ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            os_cnt  <= os_nx;
            bit_cnt <= bit_nx;
            shift   <= shift_nx;
        end
    end

    always_comb begin
        state_nx = state;
        os_nx    = os_cnt;
        bit_nx   = bit_cnt;
        shift_nx = shift;
        offer    = 1'b0;
        ferr     = 1'b0;
        if (clk_uart_os) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nx = START;
                        os_nx    = '0;
                    end
                end
                START: begin
                    if (os_cnt == HALF) begin
                        os_nx    = '0;
                        bit_nx   = '0;
                        // A start bit gone high by its midpoint was a glitch
                        state_nx = rxd_s ? IDLE : DATA;
                    end else begin
                        os_nx = os_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (os_cnt == FULL) begin
                        shift_nx = {rxd_s, shift[7:1]};
                        os_nx    = '0;
                        bit_nx   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nx = STOP;
                        end
                    end else begin
                        os_nx = os_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (os_cnt == FULL) begin
                        os_nx = '0;
                        if (rxd_s) begin
                            offer    = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            ferr     = 1'b1;
                            state_nx = BREAK;
                        end
                    end else begin
                        os_nx = os_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Hold off until the line is released so a stuck-low
                    // line cannot produce a stream of bogus frames
                    if (rxd_s) begin
                        state_nx = IDLE;
                        os_nx    = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    os_nx    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= offer && valid && !ready;
            // A byte accepted on the load cycle frees the slot for the new one
            if (offer && (!valid || ready)) begin
                data  <= shift;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx (OSR=16, tick every 4 clk).
// Expected bytes are queued as frames are sent and checked on each handshake.
module tb_uart_rx;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_uart_os = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int vcnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int tcnt = 0;

    logic [7:0] q[$];
    logic [7:0] exp_b;

    uart_rx #(.OSR(16)) dut (
        .clk(clk),
        .rst(rst),
        .clk_uart_os(clk_uart_os),
        .rxd(rxd),
        .data(data),
        .valid(valid),
        .ready(ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tcnt = (tcnt + 1) % 4;
        clk_uart_os = (tcnt == 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) vcnt++;
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (valid && ready) begin
                hs_cnt++;
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $error("FAIL hs_unexpected: got %h, expected no byte", data);
                end else begin
                    exp_b = q.pop_front();
                    assert (data === exp_b) else begin
                        n_err++;
                        $error("FAIL hs_data: got %h, expected %h", data, exp_b);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(BIT);
        end
        rxd = stop;
        cyc(BIT);
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data), 'h00);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_ovr", int'(overrun), 0);
        cyc(BIT);

        // good byte
        ready = 1'b1;
        q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        cyc(8);
        chk("good_hs", hs_cnt, 1);
        chk("good_vcyc", vcnt, 1);
        chk("good_busy", int'(busy), 0);
        chk("good_ferr", ferr_cnt, 0);
        chk("good_ovr", ovr_cnt, 0);

        // overrun
        ready = 1'b0;
        q.push_back(8'h00);
        send(8'h00, 1'b1);
        chk("ovr_valid1", int'(valid), 1);
        chk("ovr_data1", int'(data), 'h00);
        send(8'hFF, 1'b1);
        cyc(8);
        chk("ovr_cnt", ovr_cnt, 1);
        chk("ovr_data2", int'(data), 'h00);
        chk("ovr_valid2", int'(valid), 1);
        ready = 1'b1;
        cyc(1);
        chk("ovr_clear", int'(valid), 0);
        chk("ovr_hs", hs_cnt, 2);
        cyc(BIT);

        // framing error, held-low line, recovery
        send(8'h3C, 1'b0);
        cyc(3 * BIT);
        chk("fe_cnt", ferr_cnt, 1);
        chk("fe_break_busy", int'(busy), 1);
        rxd = 1'b1;
        cyc(BIT);
        chk("fe_idle", int'(busy), 0);
        q.push_back(8'h81);
        send(8'h81, 1'b1);
        cyc(8);
        chk("fe_hs", hs_cnt, 3);
        chk("fe_cnt2", ferr_cnt, 1);
        cyc(BIT);

        // start glitch
        rxd = 1'b0;
        cyc(16);
        rxd = 1'b1;
        chk("gl_busy", int'(busy), 1);
        cyc(40);
        chk("gl_idle", int'(busy), 0);
        chk("gl_hs", hs_cnt, 3);
        chk("gl_ferr", ferr_cnt, 1);
        cyc(BIT);

        // reset mid-frame (during bit 3 of 0xC3)
        rxd = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 3; i++) begin
            rxd = ((8'hC3 >> i) & 8'h01) != 0;
            cyc(BIT);
        end
        rxd = 1'b0;
        cyc(BIT / 2);
        rxd = 1'b1;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rm_busy", int'(busy), 0);
        chk("rm_valid", int'(valid), 0);
        cyc(2 * BIT);
        chk("rm_hs", hs_cnt, 3);
        chk("rm_ferr", ferr_cnt, 1);
        chk("rm_ovr", ovr_cnt, 1);
        q.push_back(8'h5A);
        send(8'h5A, 1'b1);
        cyc(8);
        chk("rm_hs2", hs_cnt, 4);
        cyc(BIT);

        // accept and load on the same cycle
        ready = 1'b0;
        q.push_back(8'h12);
        send(8'h12, 1'b1);
        cyc(8);
        chk("al_valid1", int'(valid), 1);
        chk("al_data1", int'(data), 'h12);
        cyc(20);
        // Start the next frame where the tick phase puts the load on a
        // known cycle: detection 3 cycles in, stop sample 152 ticks later.
        for (int i = 0; i < 4 && tcnt != 1; i++) cyc(1);
        q.push_back(8'h34);
        fork
            send(8'h34, 1'b1);
            begin
                cyc(610);
                chk("al_pre_valid", int'(valid), 1);
                chk("al_pre_data", int'(data), 'h12);
                ready = 1'b1;
                cyc(1);
                ready = 1'b0;
                chk("al_valid2", int'(valid), 1);
                chk("al_data2", int'(data), 'h34);
            end
        join
        chk("al_ovr", ovr_cnt, 1);
        chk("al_hs", hs_cnt, 5);
        ready = 1'b1;
        cyc(4);
        chk("end_valid", int'(valid), 0);
        chk("end_hs", hs_cnt, 6);
        chk("end_q", q.size(), 0);
        chk("end_ferr", ferr_cnt, 1);
        chk("end_ovr", ovr_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
